// File: rtl/shift_mix_stage.sv
// shift_mix_stage: registered AES ShiftRows + MixColumns stage with valid/ready handshake.
// Define SHIFT_MIX_SKID_EN for a two-entry skid buffer with a registered in_ready.
module shift_mix_stage (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         out_last
);
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Column c gathers row r from input column (c+r) mod 4, then mixes unless last round.
  function automatic logic [127:0] shift_mix(input logic [127:0] s, input logic last);
    logic [7:0]   a [4];
    logic [31:0]  m;
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) a[i] = s[127-8*(4*((c+i)%4)+i) -: 8];
      m = {xt(a[0]) ^ xt(a[1]) ^ a[1] ^ a[2] ^ a[3],
           a[0] ^ xt(a[1]) ^ xt(a[2]) ^ a[2] ^ a[3],
           a[0] ^ a[1] ^ xt(a[2]) ^ xt(a[3]) ^ a[3],
           xt(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xt(a[3])};
      r[127-32*c -: 32] = last ? {a[0], a[1], a[2], a[3]} : m;
    end
    return r;
  endfunction

  logic [127:0] mixed;
  logic [127:0] data_q, data_d;
  logic         valid_q, valid_d, last_q, last_d;
  logic         accept;

  assign mixed     = shift_mix(in_state, in_last);
  assign out_state = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;

`ifdef SHIFT_MIX_SKID_EN
  logic [127:0] skid_q, skid_d;
  logic         skid_v_q, skid_v_d, skid_last_q, skid_last_d;
  logic         load;

  assign in_ready = !skid_v_q;
  assign accept   = in_valid && !skid_v_q;
  assign load     = !valid_q || out_ready;

  // The skid entry always drains to the output before any new word.
  always_comb begin
    data_d      = load ? (skid_v_q ? skid_q : (accept ? mixed : data_q)) : data_q;
    last_d      = load ? (skid_v_q ? skid_last_q : (accept ? in_last : last_q)) : last_q;
    valid_d     = load ? (skid_v_q || accept) : valid_q;
    skid_d      = (!load && accept) ? mixed : skid_q;
    skid_last_d = (!load && accept) ? in_last : skid_last_q;
    skid_v_d    = !load && (skid_v_q || accept);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skid_q      <= '0;
      skid_last_q <= 1'b0;
      skid_v_q    <= 1'b0;
    end else begin
      skid_q      <= skid_d;
      skid_last_q <= skid_last_d;
      skid_v_q    <= skid_v_d;
    end
  end
`else
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    data_d  = accept ? mixed : data_q;
    last_d  = accept ? in_last : last_q;
    valid_d = accept || (valid_q && !out_ready);
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: tb/tb_shift_mix_stage.sv
// tb_shift_mix_stage: directed checks of the ShiftRows/MixColumns stage, both buffer configurations.
module tb_shift_mix_stage;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_state;
  logic         out_last;

  int checks = 0;
  int errors = 0;

  shift_mix_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] n);
    logic [7:0] p, a;
    p = '0;
    a = x;
    for (int i = 0; i < 8; i++) begin
      if (n[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_fn(input logic [127:0] s, input bit last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   cf [4];
    logic [7:0]   v;
    logic [127:0] r;
    cf = '{8'd2, 8'd3, 8'd1, 8'd1};
    for (int k = 0; k < 16; k++) b[k] = s[127-8*k -: 8];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) t[4*c+rr] = b[4*((c+rr)%4)+rr];
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) begin
        v = '0;
        for (int j = 0; j < 4; j++)
          v ^= last ? ((j == rr) ? t[4*c+j] : 8'h00) : gmul(t[4*c+j], cf[(j-rr+4)%4]);
        r[127-8*(4*c+rr) -: 8] = v;
      end
    return r;
  endfunction

  initial begin
    logic [127:0] words [16];
    logic [127:0] q [$];
    logic [127:0] held;
    logic [127:0] fips;
    int acc;
    int got;
    int exp_acc;
    bit a;
`ifdef SHIFT_MIX_SKID_EN
    exp_acc = 2;
`else
    exp_acc = 1;
`endif
    for (int i = 0; i < 16; i++)
      words[i] = {32'h0011_2233 + i, 32'h4455_6677 * (i + 1), 32'hdead_beef ^ i, 32'h0f1e_2d3c << i};
    fips = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;

    in_valid = 1'b1;
    in_state = 128'hffff_0000_aaaa_5555_1234_5678_9abc_def0;
    in_last  = 1'b1;
    tick;
    tick;
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_state", out_state, 128'h0);
    chk("reset_last", out_last, 1'b0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    tick;
    chk("post_reset_ready", in_ready, 1'b1);
    chk("post_reset_valid", out_valid, 1'b0);

    in_valid = 1'b1;
    in_state = fips;
    in_last  = 1'b0;
    tick;
    in_valid = 1'b0;
    chk("fips_valid", out_valid, 1'b1);
    chk("fips_round1", out_state, 128'h046681e5_e0cb199a_48f8d37a_2806264c);
    chk("fips_last_flag", out_last, 1'b0);
    tick;
    chk("drain_valid", out_valid, 1'b0);

    in_valid = 1'b1;
    in_last  = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("final_round", out_state, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5);
    chk("final_last_flag", out_last, 1'b1);
    tick;

    in_valid = 1'b1;
    in_state = 128'hdb000000_00130000_00005300_00000045;
    in_last  = 1'b0;
    tick;
    in_valid = 1'b0;
    chk("single_column", out_state, 128'h8e4da1bc_00000000_00000000_00000000);
    tick;

    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_state = words[i];
      in_last  = (i % 2) == 1;
      chk("stream_ready", in_ready, 1'b1);
      tick;
      chk("stream_valid", out_valid, 1'b1);
      chk("stream_data", out_state, ref_fn(words[i], (i % 2) == 1));
      chk("stream_last", out_last, (i % 2) == 1);
    end
    in_valid = 1'b0;
    tick;
    chk("stream_drained", out_valid, 1'b0);

    acc       = 0;
    got       = 0;
    held      = '0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_last   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_state = words[8+acc];
      a = in_valid && in_ready;
      tick;
      if (a) begin
        q.push_back(ref_fn(words[8+acc], 1'b0));
        acc++;
      end
      if (i == 0) begin
        chk("stall_fill_valid", out_valid, 1'b1);
        held = out_state;
      end else begin
        chk("stall_hold", out_state, held);
      end
    end
    chk("stall_in_ready", in_ready, 1'b0);
    chk("stall_accepts", acc, exp_acc);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) begin
        got++;
        if (q.size() > 0) chk("drain_order", out_state, q.pop_front());
      end
      tick;
    end
    chk("drain_count", got, acc);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_state  = words[3];
    tick;
    tick;
    chk("pre_reset_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    tick;
    chk("stall_reset_valid", out_valid, 1'b0);
    chk("stall_reset_state", out_state, 128'h0);
    chk("stall_reset_last", out_last, 1'b0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    tick;
    chk("after_reset_ready", in_ready, 1'b1);
    chk("after_reset_valid", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_mix_stage.md
# shift_mix_stage

Registered ShiftRows + MixColumns stage of the AES encryption round datapath. Consumes the 128-bit state produced by the SubBytes stage through a valid/ready handshake, applies ShiftRows and, except on the final round, MixColumns, and presents the result to the AddRoundKey stage. The `in_last` flag is carried alongside the data so the downstream controller knows which round it is handling.

## Interface
- No parameters; the datapath width is fixed at 128 bits.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: `in_state`/`in_last` are valid.
- `in_ready` output 1: stage can accept; a transfer occurs when `in_valid && in_ready` at a rising edge.
- `in_state` input 128: state after SubBytes.
- `in_last` input 1: final round; MixColumns is skipped.
- `out_valid` output 1: `out_state`/`out_last` are valid.
- `out_ready` input 1: downstream accepts; a transfer occurs when `out_valid && out_ready`.
- `out_state` output 128: state after ShiftRows, and after MixColumns when not the last round.
- `out_last` output 1: registered copy of `in_last`.

## Operation
- Byte order:
  - byte k = `state[127-8k -: 8]`, k = 0..15.
  - Row r, column c = byte 4c+r (FIPS-197 column-major).
- ShiftRows: out(r,c) = in(r,(c+r) mod 4), i.e. row r rotates left by r bytes.
- MixColumns, per column (a0..a3 → b0..b3):
  - b0 = 2a0^3a1^a2^a3.
  - b1 = a0^2a1^3a2^a3.
  - b2 = a0^a1^2a2^3a3.
  - b3 = 3a0^a1^a2^2a3.
  - 2x = {x[6:0],0} ^ (x[7] ? 8'h1B : 0).
  - 3x = 2x ^ x.
- When `in_last`=1, ShiftRows only.
- The transform is computed combinationally on the input side, then registered. The output is driven only from flops.
- Data and `out_last` never change while `out_valid && !out_ready` (the stall-stability rule).
- Transfers are in order; none are dropped or duplicated.

## Timing
- Reset (`rst_n` low at an edge):
  - `out_valid`=0, `out_state`=0, `out_last`=0.
  - Any internal buffer is emptied.
  - `in_ready`=1 from the first cycle after reset.
  - Inputs are ignored while `rst_n` is low.
- Latency: accepted at edge N → `out_valid`=1 with the result after edge N.
- Throughput: one transfer per cycle while `out_ready`=1.
- Simultaneous accept and drain in the same cycle: the new word replaces the drained one, with no bubble.
- `out_ready` low: the output holds. Further accepts obey the buffer depth (see Configuration). Once full, `in_ready`=0.
- Reset asserted mid-stall: all in-flight data is discarded, and `out_valid`=0 after that edge.

## Configuration
- `SHIFT_MIX_SKID_EN` defined:
  - Two-entry skid buffer (output register + skid register).
  - `in_ready` is a flop: 1 unless the skid register is occupied.
  - With `out_ready` low, one more word is accepted after the output fills, then `in_ready` drops the next cycle.
  - On release, the skid entry moves to the output first.
  - There is no combinational path from `out_ready` to `in_ready`.
- Not defined:
  - Single output register.
  - `in_ready` = `!out_valid || out_ready` (combinational).
  - With `out_ready` low and the output full, no further word is accepted.

## Test plan
- FIPS-197 round 1, `in_last`=0, `out_ready`=1:
  - Stimulus: `in_state`=d4271 1ae e0bf98f1 b8b45de5 1e415230 (hex, byte 0 first), i.e. d42711ae e0bf98f1 b8b45de5 1e415230.
  - Required: one cycle later `out_state`=046681e5 e0cb199a 48f8d37a 2806264c, `out_last`=0.
- Same input with `in_last`=1 → `out_state`=d4bf5d30 e0b452ae b84111f1 1e2798e5, `out_last`=1.
- Single column:
  - Stimulus: column 0 = db 13 53 45, other columns 00, `in_last`=0.
  - Required: output column 0 = 8e 4d a1 bc (input row rotation precomputed so that column 0 sees these bytes after ShiftRows); other columns = 00.
- Back-to-back stream of 8 distinct words with `out_ready`=1:
  - Required: 8 outputs in order on consecutive cycles, no bubbles.
- Back-pressure:
  - Stimulus: `out_ready` held 0 for 5 cycles while `in_valid`=1.
  - Required: `out_state` stable throughout. Accepted count is 2 with the macro, 1 without. After release, all words arrive in order with no loss or duplication.
- Reset pulse while stalled with data held → `out_valid`=0, `out_state`=0, `in_ready`=1 the cycle after reset deasserts.
